// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared timing constants for the 640x480@60 VGA read path.
//   Also holds the 2-bit axis state encoding and a helper that maps an
//   axis count to its state.
package vga_timing_pkg;

    localparam int COUNT_W = 10;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FRONT  = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BACK   = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FRONT  = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BACK   = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    typedef enum logic [1:0] {
        AXIS_ACTIVE = 2'd0,
        AXIS_FRONT  = 2'd1,
        AXIS_SYNC   = 2'd2,
        AXIS_BACK   = 2'd3
    } axis_state_t;

    // Region boundaries are cumulative: ACTIVE, then FRONT, then SYNC,
    // and everything up to the end of the line/frame is BACK.
    function automatic axis_state_t axis_state_of(input logic [COUNT_W-1:0] count,
                                                  input int active,
                                                  input int front,
                                                  input int sync);
        int c;
        c = {{(32-COUNT_W){1'b0}}, count};
        if (c < active)
            return AXIS_ACTIVE;
        else if (c < active + front)
            return AXIS_FRONT;
        else if (c < active + front + sync)
            return AXIS_SYNC;
        else
            return AXIS_BACK;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
//   One timing axis (horizontal or vertical): a counter over
//   ACTIVE+FRONT+SYNC+BACK positions with its region state.
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   synchronous, active-low; count returns to 0
//   step        in   advance the count by one on this clock
//   count       out  current position (registered)
//   state_next  out  region of the position being loaded at this edge,
//                    so the parent can register its outputs without lag
//   wrap        out  step taken at the last position (count returns to 0)
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = VGA_H_ACTIVE,
    parameter int FRONT  = VGA_H_FRONT,
    parameter int SYNC   = VGA_H_SYNC,
    parameter int BACK   = VGA_H_BACK
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               step,
    output logic [COUNT_W-1:0] count,
    output axis_state_t        state_next,
    output logic               wrap
);

    localparam int                 TOTAL = ACTIVE + FRONT + SYNC + BACK;
    localparam logic [COUNT_W-1:0] LAST  = COUNT_W'(TOTAL - 1);

    logic [COUNT_W-1:0] count_next;

    always_comb begin
        wrap       = step && (count == LAST);
        count_next = count;
        if (wrap)
            count_next = '0;
        else if (step)
            count_next = count + 1'b1;
        state_next = axis_state_of(count_next, ACTIVE, FRONT, SYNC);
    end

    always_ff @(posedge clock) begin
        if (!reset)
            count <= '0;
        else
            count <= count_next;
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl
//   Generates VGA horizontal/vertical timing from a pixel-rate tick and
//   issues one pixel_enable strobe per visible pixel of a displayed frame.
// Ports:
//   clock         in   system clock, rising edge
//   reset         in   synchronous, active-low
//   enable        in   pixel-rate tick; counters advance only when high
//   display_en    in   show frames; sampled only when the frame wraps
//   hsync_n       out  horizontal sync, active-low (registered)
//   vsync_n       out  vertical sync, active-low (registered)
//   video_on      out  visible position of a displayed frame (registered)
//   x, y          out  current column / line (registered)
//   pixel_enable  out  enable & video_on & reset (combinational)
//   frame_start   out  enable & reset at position (0,0) (combinational)
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FRONT  = VGA_H_FRONT,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BACK   = VGA_H_BACK,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FRONT  = VGA_V_FRONT,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BACK   = VGA_V_BACK
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               display_en,
    output logic               hsync_n,
    output logic               vsync_n,
    output logic               video_on,
    output logic [COUNT_W-1:0] x,
    output logic [COUNT_W-1:0] y,
    output logic               pixel_enable,
    output logic               frame_start
);

    logic [COUNT_W-1:0] h_count;
    logic [COUNT_W-1:0] v_count;
    axis_state_t        h_state_next;
    axis_state_t        v_state_next;
    logic               h_wrap;
    logic               v_wrap;
    logic               display_active;
    logic               display_active_next;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK)
    ) u_h_axis (
        .clock      (clock),
        .reset      (reset),
        .step       (enable),
        .count      (h_count),
        .state_next (h_state_next),
        .wrap       (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK)
    ) u_v_axis (
        .clock      (clock),
        .reset      (reset),
        .step       (h_wrap),
        .count      (v_count),
        .state_next (v_state_next),
        .wrap       (v_wrap)
    );

    // v_wrap only fires on the tick that takes (last, last) to (0, 0),
    // so the display decision is made exactly at frame boundaries.
    assign display_active_next = v_wrap ? display_en : display_active;

    // Outputs are loaded from the next-count state so they line up with
    // x/y on the same edge. With enable low the next state equals the
    // current one, so every register simply holds.
    always_ff @(posedge clock) begin
        if (!reset) begin
            display_active <= 1'b1;
            video_on       <= 1'b1;
            hsync_n        <= 1'b1;
            vsync_n        <= 1'b1;
        end else begin
            display_active <= display_active_next;
            video_on       <= display_active_next &&
                              (h_state_next == AXIS_ACTIVE) &&
                              (v_state_next == AXIS_ACTIVE);
            hsync_n        <= (h_state_next != AXIS_SYNC);
            vsync_n        <= (v_state_next != AXIS_SYNC);
        end
    end

    assign x = h_count;
    assign y = v_count;

    assign pixel_enable = enable & video_on & reset;
    assign frame_start  = enable & reset & (h_count == '0) & (v_count == '0);

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl
//   Directed bench. A full-size instance checks one 800-tick line; a
//   reduced-timing instance (15 ticks x 10 lines, 8x6 visible, hsync at
//   x=10..12, vsync at y=7..8) covers whole-frame behaviour.
module tb_vga_timing_ctrl;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       display_en;

    logic       s_hsync_n, s_vsync_n, s_video_on, s_pixel_enable, s_frame_start;
    logic [9:0] s_x, s_y;
    logic       d_hsync_n, d_vsync_n, d_video_on, d_pixel_enable, d_frame_start;
    logic [9:0] d_x, d_y;

    int n_chk = 0;
    int n_err = 0;

    int mx, my;

    vga_timing_ctrl #(
        .H_ACTIVE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
        .V_ACTIVE (6), .V_FRONT (1), .V_SYNC (2), .V_BACK (1)
    ) u_small (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .display_en   (display_en),
        .hsync_n      (s_hsync_n),
        .vsync_n      (s_vsync_n),
        .video_on     (s_video_on),
        .x            (s_x),
        .y            (s_y),
        .pixel_enable (s_pixel_enable),
        .frame_start  (s_frame_start)
    );

    vga_timing_ctrl u_full (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .display_en   (display_en),
        .hsync_n      (d_hsync_n),
        .vsync_n      (d_vsync_n),
        .video_on     (d_video_on),
        .x            (d_x),
        .y            (d_y),
        .pixel_enable (d_pixel_enable),
        .frame_start  (d_frame_start)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1ms;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic advance_model();
        mx++;
        if (mx == 15) begin
            mx = 0;
            my++;
            if (my == 10) my = 0;
        end
    endtask

    // Runs one frame of the small instance from (0,0). toggle selects a
    // 1-0 enable pattern; display_en is set to chg_val before enable tick
    // chg_tick (-1 = never). da is the display state of this frame.
    task automatic run_frame(input string tag, input bit toggle, input bit da,
                             input int chg_tick, input bit chg_val, input int exp_pe);
        int  cycles, ticks, pe, fs, vs, bad;
        bit  en;
        cycles = toggle ? 300 : 150;
        ticks = 0; pe = 0; fs = 0; vs = 0; bad = 0;
        for (int c = 0; c < cycles; c++) begin
            en = toggle ? (c % 2 == 0) : 1'b1;
            if (en && ticks == chg_tick) display_en = chg_val;
            enable = en;
            @(negedge clock);
            if (int'(s_x) != mx || int'(s_y) != my) bad++;
            if (s_hsync_n != !(mx >= 10 && mx <= 12)) bad++;
            if (s_vsync_n != !(my >= 7 && my <= 8)) bad++;
            if (s_video_on != (da && mx < 8 && my < 6)) bad++;
            if (!en && (s_pixel_enable || s_frame_start)) bad++;
            if (en) begin
                ticks++;
                if (s_pixel_enable) pe++;
                if (s_frame_start) begin
                    fs++;
                    if (mx != 0 || my != 0) bad++;
                end
                if (!s_vsync_n) vs++;
            end
            @(posedge clock);
            #1;
            if (en) advance_model();
        end
        check_val({tag, "_ticks"}, ticks, 150);
        check_val({tag, "_pixel_enables"}, pe, exp_pe);
        check_val({tag, "_frame_starts"}, fs, 1);
        check_val({tag, "_vsync_low_ticks"}, vs, 30);
        check_val({tag, "_track_errors"}, bad, 0);
    endtask

    int rbad, hs_fall, hs_rise, vo_fall, d_pe, d_vs_bad, x799, y799, end_x, end_y, guard;

    initial begin
        reset      = 1'b0;
        enable     = 1'b1;
        display_en = 1'b1;
        rbad       = 0;

        // Reset held low for 3 clocks with enable high
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            if (c > 0 && (s_pixel_enable || s_frame_start || d_pixel_enable || d_frame_start))
                rbad++;
            @(posedge clock);
            #1;
        end
        @(negedge clock);
        check_val("reset_strobes", rbad, 0);
        check_val("reset_x", int'(s_x), 0);
        check_val("reset_y", int'(s_y), 0);
        check_val("reset_hsync_n", int'(s_hsync_n), 1);
        check_val("reset_vsync_n", int'(s_vsync_n), 1);
        check_val("reset_video_on", int'(s_video_on), 1);
        check_val("reset_full_video_on", int'(d_video_on), 1);
        check_val("reset_pixel_enable", int'(s_pixel_enable), 0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // One full-size line
        hs_fall = -1; hs_rise = -1; vo_fall = -1; d_pe = 0; d_vs_bad = 0;
        x799 = -1; y799 = -1; end_x = -1; end_y = -1;
        for (int k = 0; k <= 800; k++) begin
            @(negedge clock);
            if (k < 800) begin
                if (hs_fall < 0 && !d_hsync_n) hs_fall = int'(d_x);
                else if (hs_fall >= 0 && hs_rise < 0 && d_hsync_n) hs_rise = int'(d_x);
                if (vo_fall < 0 && !d_video_on) vo_fall = int'(d_x);
                if (!d_vsync_n) d_vs_bad++;
                if (d_pixel_enable) d_pe++;
                if (k == 799) begin
                    x799 = int'(d_x);
                    y799 = int'(d_y);
                end
            end else begin
                end_x = int'(d_x);
                end_y = int'(d_y);
            end
            @(posedge clock);
            #1;
        end
        check_val("line_hsync_fall_x", hs_fall, 656);
        check_val("line_hsync_rise_x", hs_rise, 752);
        check_val("line_video_off_x", vo_fall, 640);
        check_val("line_pixel_enables", d_pe, 640);
        check_val("line_vsync_low", d_vs_bad, 0);
        check_val("line_last_x", x799, 799);
        check_val("line_last_y", y799, 0);
        check_val("line_next_x", end_x, 0);
        check_val("line_next_y", end_y, 1);

        // Restart both instances at (0,0) for the frame tests
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        mx = 0;
        my = 0;

        run_frame("frame_tied", 1'b0, 1'b1, -1, 1'b1, 48);
        run_frame("frame_toggle", 1'b1, 1'b1, -1, 1'b1, 48);
        // Drop display_en mid-frame at (4,3): tick 3*15+4
        run_frame("frame_drop", 1'b0, 1'b1, 49, 1'b0, 48);
        run_frame("frame_blank", 1'b0, 1'b0, -1, 1'b0, 0);
        // Raise display_en mid-frame: still blank until the wrap
        run_frame("frame_raise", 1'b0, 1'b0, 70, 1'b1, 0);
        run_frame("frame_resumed", 1'b0, 1'b1, -1, 1'b1, 48);

        // Mid-frame reset at (11,4), inside the horizontal sync pulse
        guard = 0;
        enable = 1'b1;
        while (!(mx == 11 && my == 4) && guard < 200) begin
            @(posedge clock);
            #1;
            advance_model();
            guard++;
        end
        check_val("midrst_reached", int'(guard < 200), 1);
        @(negedge clock);
        check_val("midrst_pre_hsync_n", int'(s_hsync_n), 0);
        reset = 1'b0;
        #1;
        check_val("midrst_pixel_enable", int'(s_pixel_enable), 0);
        check_val("midrst_frame_start", int'(s_frame_start), 0);
        @(posedge clock);
        #1;
        @(negedge clock);
        check_val("midrst_x", int'(s_x), 0);
        check_val("midrst_y", int'(s_y), 0);
        check_val("midrst_hsync_n", int'(s_hsync_n), 1);
        check_val("midrst_vsync_n", int'(s_vsync_n), 1);
        check_val("midrst_video_on", int'(s_video_on), 1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        mx = 0;
        my = 0;
        run_frame("frame_after_reset", 1'b0, 1'b1, -1, 1'b1, 48);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
